// File: rtl/edge_pulse_meter_pkg.sv
// Shared types and default sizes for the edge pulse meter.
package edge_pulse_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } meter_state_t;

    localparam int WIDTH_W_DEF = 8;
    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/edge_pulse_meter_sat_counter.sv
// Saturating up-counter: load 1, increment-and-hold at all-ones, or hold.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_one,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    assign sat = (cnt == {W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load_one) begin
            cnt <= W'(1);
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/edge_pulse_meter.sv
// Measures the high time of a signal from its rising/falling edge pulses and
// presents each width on a valid/ready port. Optional ovf_o: EDGE_PULSE_METER_OVF_EN.
//
//   state   | meaning
//   IDLE    | waiting for a rising edge
//   MEASURE | signal high, cnt counting cycles since the rising edge
module edge_pulse_meter
    import edge_pulse_meter_pkg::*;
#(
    parameter int WIDTH_W = WIDTH_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rising_edge_i,
    input  logic               falling_edge_i,
    input  logic               width_ready_i,
    output logic [WIDTH_W-1:0] width_o,
    output logic               width_valid_o,
    output logic [CNT_W-1:0]   pulse_count_o,
    output logic               drop_o
`ifdef EDGE_PULSE_METER_OVF_EN
    ,
    output logic               ovf_o
`endif
);

    meter_state_t       state;
    logic [WIDTH_W-1:0] cnt;
    logic               cnt_sat;
    logic               rise_only;
    logic               fall_only;
    logic               no_edge;
    logic               complete;
    logic               accept;

    // Both edges in one cycle is a protocol violation and falls through every case.
    assign rise_only = rising_edge_i & ~falling_edge_i;
    assign fall_only = falling_edge_i & ~rising_edge_i;
    assign no_edge   = ~rising_edge_i & ~falling_edge_i;
    assign complete  = (state == MEASURE) & fall_only;
    assign accept    = width_valid_o & width_ready_i;

    sat_counter #(.W(WIDTH_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load_one (rise_only),
        .inc      ((state == MEASURE) & no_edge & ~cnt_sat),
        .cnt      (cnt),
        .sat      (cnt_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            width_o       <= '0;
            width_valid_o <= 1'b0;
            pulse_count_o <= '0;
            drop_o        <= 1'b0;
`ifdef EDGE_PULSE_METER_OVF_EN
            ovf_o         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:    if (rise_only) state <= MEASURE;
                MEASURE: if (fall_only) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (complete) begin
                pulse_count_o <= pulse_count_o + 1'b1;
                // A result being accepted this cycle frees the register for the new one.
                if (!width_valid_o || accept) begin
                    width_o       <= cnt;
                    width_valid_o <= 1'b1;
`ifdef EDGE_PULSE_METER_OVF_EN
                    ovf_o         <= cnt_sat;
`endif
                end else begin
                    drop_o <= 1'b1;
                end
            end else if (accept) begin
                width_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_pulse_meter.sv
// Randomized and directed bench for edge_pulse_meter (WIDTH_W=4) against a
// timestamp-based reference model.
module tb_edge_pulse_meter;

    localparam int WIDTH_W = 4;
    localparam int CNT_W   = 16;
    localparam int WMAX    = (1 << WIDTH_W) - 1;

    logic               clk;
    logic               reset;
    logic               rising_edge_i;
    logic               falling_edge_i;
    logic               width_ready_i;
    logic [WIDTH_W-1:0] width_o;
    logic               width_valid_o;
    logic [CNT_W-1:0]   pulse_count_o;
    logic               drop_o;
`ifdef EDGE_PULSE_METER_OVF_EN
    logic               ovf_o;
`endif

    edge_pulse_meter #(.WIDTH_W(WIDTH_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .rising_edge_i  (rising_edge_i),
        .falling_edge_i (falling_edge_i),
        .width_ready_i  (width_ready_i),
        .width_o        (width_o),
        .width_valid_o  (width_valid_o),
        .pulse_count_o  (pulse_count_o),
        .drop_o         (drop_o)
`ifdef EDGE_PULSE_METER_OVF_EN
        ,
        .ovf_o          (ovf_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a pulse is a rise timestamp; width is elapsed cycles
    // minus cycles wasted on simultaneous-edge violations, clipped to WMAX.
    bit measuring  = 0;
    int rise_t     = 0;
    int both_cnt   = 0;
    int cyc        = 0;
    int e_width    = 0;
    bit e_valid    = 0;
    int e_count    = 0;
    bit e_drop     = 0;
    bit e_ovf      = 0;
    bit sig_hi     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit f, input bit rdy, input bit rst);
        bit accept;
        bit done;
        int raw;
        done = 0;
        raw  = 0;
        if (rst) begin
            measuring = 0;
            e_width = 0; e_valid = 0; e_count = 0; e_drop = 0; e_ovf = 0;
        end else begin
            accept = e_valid && rdy;
            if (measuring) begin
                if (r && f) both_cnt++;
                else if (r) begin rise_t = cyc; both_cnt = 0; end
                else if (f) begin
                    done = 1;
                    raw = cyc - rise_t - both_cnt;
                    measuring = 0;
                end
            end else if (r && !f) begin
                measuring = 1; rise_t = cyc; both_cnt = 0;
            end
            if (done) begin
                e_count = (e_count + 1) % (1 << CNT_W);
                if (!e_valid || accept) begin
                    e_width = (raw >= WMAX) ? WMAX : raw;
                    e_ovf   = (raw >= WMAX);
                    e_valid = 1;
                end else begin
                    e_drop = 1;
                end
            end else if (accept) begin
                e_valid = 0;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit r, input bit f, input bit rdy, input bit rst);
        rising_edge_i  = r;
        falling_edge_i = f;
        width_ready_i  = rdy;
        reset          = rst;
        model(r, f, rdy, rst);
        @(posedge clk);
        @(negedge clk);
        check("valid", width_valid_o, e_valid);
        if (e_valid) check("width", width_o, e_width);
        check("count", pulse_count_o, e_count);
        check("drop", drop_o, e_drop);
`ifdef EDGE_PULSE_METER_OVF_EN
        if (e_valid) check("ovf", ovf_o, e_ovf);
`endif
    endtask

    task automatic pulse(input int w, input bit rdy_hold, input bit rdy_fall);
        step(1, 0, rdy_hold, 0);
        for (int i = 0; i < w - 1; i++) step(0, 0, rdy_hold, 0);
        step(0, 1, rdy_fall, 0);
    endtask

    initial begin
        int p;
        bit r, f, rdy, rst;
        reset = 1; rising_edge_i = 0; falling_edge_i = 0; width_ready_i = 0;
        @(negedge clk);

        // reset held with edges toggling
        step(1, 0, 1, 1); step(0, 1, 1, 1); step(1, 1, 1, 1);
        check("rst_width", width_o, 0);
        check("rst_count", pulse_count_o, 0);

        // basic pulse: width 5, valid for exactly one cycle
        step(0, 0, 1, 0);
        pulse(5, 1, 1);
        check("basic_w", width_o, 5);
        check("basic_v", width_valid_o, 1);
        check("basic_cnt", pulse_count_o, 1);
        step(0, 0, 1, 0);
        check("basic_v_next", width_valid_o, 0);

        // backpressure: second result dropped
        step(0, 0, 0, 1);
        pulse(3, 0, 0); step(0, 0, 0, 0);
        pulse(4, 0, 0); step(0, 0, 0, 0);
        check("bp_w", width_o, 3);
        check("bp_drop", drop_o, 1);
        check("bp_cnt", pulse_count_o, 2);
        step(0, 0, 1, 0);
        check("bp_xfer_v", width_valid_o, 0);
        step(0, 0, 1, 0);

        // accept and new completion in the same cycle
        step(0, 0, 0, 1);
        pulse(2, 0, 0); step(0, 0, 0, 0);
        pulse(6, 0, 1);
        check("acc_w", width_o, 6);
        check("acc_v", width_valid_o, 1);
        check("acc_drop", drop_o, 0);

        // saturation, then a short pulse clears ovf
        step(0, 0, 1, 0);
        pulse(20, 1, 1);
        check("sat_w", width_o, WMAX);
`ifdef EDGE_PULSE_METER_OVF_EN
        check("sat_ovf", ovf_o, 1);
`endif
        step(0, 0, 1, 0);
        pulse(2, 1, 1);
        check("short_w", width_o, 2);
`ifdef EDGE_PULSE_METER_OVF_EN
        check("short_ovf", ovf_o, 0);
`endif

        // irregular edges
        step(0, 0, 1, 1);
        step(0, 1, 1, 0);
        check("idle_fall_v", width_valid_o, 0);
        step(1, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(1, 0, 1, 0); step(0, 0, 1, 0); step(0, 1, 1, 0);
        check("missed_w", width_o, 2);
        check("missed_cnt", pulse_count_o, 1);
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        check("both_v", width_valid_o, 0);
        step(1, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 1);
        step(0, 1, 1, 0);
        check("rst_mid_v", width_valid_o, 0);
        check("rst_mid_cnt", pulse_count_o, 0);

        // randomized traffic
        sig_hi = 0;
        for (int i = 0; i < 4000; i++) begin
            p = $urandom_range(0, 199);
            r = 0; f = 0; rst = 0;
            rdy = ($urandom_range(0, 9) < 7);
            if (p < 1) begin rst = 1; sig_hi = 0; end
            else if (p < 6) begin r = 1; f = 1; end
            else if (p < 10) begin r = 1; sig_hi = 1; end
            else if (p < 14) f = 1;
            else if ($urandom_range(0, 99) < 15) begin
                if (sig_hi) f = 1; else r = 1;
                sig_hi = ~sig_hi;
            end
            step(r, f, rdy, rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
